// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard freeze/flush, EXE forwarding selects and memory wait-state hold for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Forward_EN,
  input  logic [4:0]       Src1_ID,
  input  logic [4:0]       Src2_ID,
  input  logic             Two_src_ID,
  input  logic [4:0]       Src1_EXE,
  input  logic [4:0]       Src2_EXE,
  input  logic             is_Immediate_EXE,
  input  logic [4:0]       Dst_EXE,
  input  logic             WB_EN_EXE,
  input  logic             MEM_R_EN_EXE,
  input  logic [4:0]       Dst_MEM,
  input  logic             WB_EN_MEM,
  input  logic             MEM_req,
  input  logic [4:0]       Dst_WB,
  input  logic             WB_EN_WB,
  input  logic             Br_taken,
  output logic             Freeze,
  output logic             Flush_IF,
  output logic             Flush_ID,
  output logic             Hold_all,
  output logic [1:0]       Fwd_A,
  output logic [1:0]       Fwd_B,
  output logic [1:0]       Fwd_ST,
  output logic [CNT_W-1:0] Stall_cnt
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic hazard;
  function automatic logic match(input logic en, input logic [4:0] d, input logic [4:0] s);
    return en && d != 5'd0 && d == s;
  endfunction
  always_comb begin
    hazard = Forward_EN
      ? MEM_R_EN_EXE && (match(WB_EN_EXE, Dst_EXE, Src1_ID) || Two_src_ID && match(WB_EN_EXE, Dst_EXE, Src2_ID))
      : match(WB_EN_EXE, Dst_EXE, Src1_ID) || match(WB_EN_MEM, Dst_MEM, Src1_ID) ||
        Two_src_ID && (match(WB_EN_EXE, Dst_EXE, Src2_ID) || match(WB_EN_MEM, Dst_MEM, Src2_ID));
    Fwd_A = !Forward_EN ? 2'b00 : match(WB_EN_MEM, Dst_MEM, Src1_EXE) ? 2'b01 :
            match(WB_EN_WB, Dst_WB, Src1_EXE) ? 2'b10 : 2'b00;
    Fwd_ST = !Forward_EN ? 2'b00 : match(WB_EN_MEM, Dst_MEM, Src2_EXE) ? 2'b01 :
             match(WB_EN_WB, Dst_WB, Src2_EXE) ? 2'b10 : 2'b00;
    Fwd_B = is_Immediate_EXE ? 2'b00 : Fwd_ST;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    Hold_all = 1'b0;
    if (state == S_IDLE) begin
      if (MEM_req) begin
        Hold_all = 1'b1;
        cnt_n = 4'(MEM_WAIT - 1);
        state_n = S_WAIT;
      end
    end else if (cnt != 4'd0) begin
      Hold_all = 1'b1;
      cnt_n = cnt - 4'd1;
    end else begin
      state_n = S_IDLE;
    end
    Freeze = Hold_all || (!Br_taken && hazard);
    Flush_IF = !Hold_all && Br_taken;
    Flush_ID = !Hold_all && (Br_taken || hazard);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      Stall_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (Freeze && !(&Stall_cnt)) Stall_cnt <= Stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic Forward_EN, Two_src_ID, is_Immediate_EXE, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM, MEM_req, WB_EN_WB, Br_taken;
  logic [4:0] Src1_ID, Src2_ID, Src1_EXE, Src2_EXE, Dst_EXE, Dst_MEM, Dst_WB;
  logic Freeze, Flush_IF, Flush_ID, Hold_all;
  logic [1:0] Fwd_A, Fwd_B, Fwd_ST;
  logic [15:0] Stall_cnt;
  logic freeze_4, flush_if_4, flush_id_4, hold_all_4;
  logic [1:0] fwd_a_4, fwd_b_4, fwd_st_4;
  logic [3:0] stall_cnt_4;
  logic [7:0] pat;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Forward_EN(Forward_EN), .Src1_ID(Src1_ID), .Src2_ID(Src2_ID),
    .Two_src_ID(Two_src_ID), .Src1_EXE(Src1_EXE), .Src2_EXE(Src2_EXE), .is_Immediate_EXE(is_Immediate_EXE),
    .Dst_EXE(Dst_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .Dst_MEM(Dst_MEM),
    .WB_EN_MEM(WB_EN_MEM), .MEM_req(MEM_req), .Dst_WB(Dst_WB), .WB_EN_WB(WB_EN_WB), .Br_taken(Br_taken),
    .Freeze(Freeze), .Flush_IF(Flush_IF), .Flush_ID(Flush_ID), .Hold_all(Hold_all),
    .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .Fwd_ST(Fwd_ST), .Stall_cnt(Stall_cnt)
  );
  pipeline_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Forward_EN(Forward_EN), .Src1_ID(Src1_ID), .Src2_ID(Src2_ID),
    .Two_src_ID(Two_src_ID), .Src1_EXE(Src1_EXE), .Src2_EXE(Src2_EXE), .is_Immediate_EXE(is_Immediate_EXE),
    .Dst_EXE(Dst_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .Dst_MEM(Dst_MEM),
    .WB_EN_MEM(WB_EN_MEM), .MEM_req(MEM_req), .Dst_WB(Dst_WB), .WB_EN_WB(WB_EN_WB), .Br_taken(Br_taken),
    .Freeze(freeze_4), .Flush_IF(flush_if_4), .Flush_ID(flush_id_4), .Hold_all(hold_all_4),
    .Fwd_A(fwd_a_4), .Fwd_B(fwd_b_4), .Fwd_ST(fwd_st_4), .Stall_cnt(stall_cnt_4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {Forward_EN, Two_src_ID, is_Immediate_EXE, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM, MEM_req, WB_EN_WB, Br_taken} = '0;
    {Src1_ID, Src2_ID, Src1_EXE, Src2_EXE, Dst_EXE, Dst_MEM, Dst_WB} = '0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask
  initial begin
    clear();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_stall_cnt", 32'(Stall_cnt), 0);
    chk("rst_hold", 32'(Hold_all), 0);
    chk("rst_freeze", 32'(Freeze), 0);
    chk("rst_fwd_a", 32'(Fwd_A), 0);
    Forward_EN = 1; MEM_R_EN_EXE = 1; WB_EN_EXE = 1; Dst_EXE = 5; Src1_ID = 5;
    #1;
    chk("lu_freeze", 32'(Freeze), 1);
    chk("lu_flush_id", 32'(Flush_ID), 1);
    chk("lu_flush_if", 32'(Flush_IF), 0);
    tick();
    chk("lu_stall_cnt", 32'(Stall_cnt), 1);
    Dst_EXE = 0;
    #1;
    chk("lu_r0_freeze", 32'(Freeze), 0);
    Dst_EXE = 5; MEM_R_EN_EXE = 0;
    #1;
    chk("lu_noload_freeze", 32'(Freeze), 0);
    clear();
    Forward_EN = 1; Dst_MEM = 7; Dst_WB = 7; WB_EN_MEM = 1; WB_EN_WB = 1; Src1_EXE = 7;
    #1;
    chk("fwd_a_mem", 32'(Fwd_A), 1);
    WB_EN_MEM = 0;
    #1;
    chk("fwd_a_wb", 32'(Fwd_A), 2);
    Src2_EXE = 7; is_Immediate_EXE = 1;
    #1;
    chk("fwd_b_imm", 32'(Fwd_B), 0);
    chk("fwd_st_wb", 32'(Fwd_ST), 2);
    is_Immediate_EXE = 0;
    #1;
    chk("fwd_b_wb", 32'(Fwd_B), 2);
    Forward_EN = 0;
    #1;
    chk("fwd_off_a", 32'(Fwd_A), 0);
    chk("fwd_off_st", 32'(Fwd_ST), 0);
    clear();
    tick();
    MEM_req = 1;
    #1;
    chk("pulse_c1", 32'(Hold_all), 1);
    tick();
    MEM_req = 0;
    chk("pulse_c2", 32'(Hold_all), 1);
    tick();
    chk("pulse_c3", 32'(Hold_all), 1);
    tick();
    chk("pulse_c4_release", 32'(Hold_all), 0);
    tick();
    chk("pulse_c5_idle", 32'(Hold_all), 0);
    do_reset();
    pat = 8'b0111_0111;
    MEM_req = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_%0d", i), 32'(Hold_all), 32'(pat[i]));
      tick();
    end
    MEM_req = 0;
    chk("b2b_stall_cnt", 32'(Stall_cnt), 6);
    Forward_EN = 1; MEM_R_EN_EXE = 1; WB_EN_EXE = 1; Dst_EXE = 5; Src1_ID = 5; Br_taken = 1;
    #1;
    chk("br_flush_if", 32'(Flush_IF), 1);
    chk("br_flush_id", 32'(Flush_ID), 1);
    chk("br_freeze", 32'(Freeze), 0);
    MEM_req = 1;
    #1;
    chk("br_hold_freeze", 32'(Freeze), 1);
    chk("br_hold_flush_if", 32'(Flush_IF), 0);
    chk("br_hold_flush_id", 32'(Flush_ID), 0);
    tick();
    MEM_req = 0;
    chk("br_wait_freeze", 32'(Freeze), 1);
    chk("br_wait_flush_if", 32'(Flush_IF), 0);
    tick();
    tick();
    chk("br_release_hold", 32'(Hold_all), 0);
    chk("br_release_flush_if", 32'(Flush_IF), 1);
    clear();
    tick();
    MEM_req = 1;
    tick();
    rst = 0;
    #1;
    chk("rstw_hold_before", 32'(Hold_all), 1);
    tick();
    rst = 1; MEM_req = 0;
    #1;
    chk("rstw_hold_after", 32'(Hold_all), 0);
    chk("rstw_stall_cnt", 32'(Stall_cnt), 0);
    Dst_MEM = 9; WB_EN_MEM = 1; Src2_ID = 9; Two_src_ID = 1;
    #1;
    chk("nf_src2_freeze", 32'(Freeze), 1);
    chk("nf_src2_flush_id", 32'(Flush_ID), 1);
    Two_src_ID = 0;
    #1;
    chk("nf_one_src_freeze", 32'(Freeze), 0);
    Two_src_ID = 1; Dst_MEM = 0; Src2_ID = 0;
    #1;
    chk("nf_r0_freeze", 32'(Freeze), 0);
    Dst_EXE = 3; WB_EN_EXE = 1; Src1_ID = 3;
    #1;
    chk("nf_exe_src1_freeze", 32'(Freeze), 1);
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt4", 32'(stall_cnt_4), 15);
    chk("sat_cnt16", 32'(Stall_cnt), 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. Detects ID-stage data hazards and issues freeze/bubble, flushes on taken branches, generates EXE-stage forwarding selects, and sequences multi-cycle data-memory accesses with a wait-state FSM that holds the whole pipeline. It drives the Freeze/Flush inputs of the IF and ID/EXE stage registers and the EXE operand muxes.

Parameters:
MEM_WAIT, 3, number of stall cycles per data-memory access; legal range 1..15
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
Forward_EN  in  1  1 = forwarding unit enabled
Src1_ID  in  5  rs of instruction in ID
Src2_ID  in  5  rt of instruction in ID
Two_src_ID  in  1  ID instruction reads Src2 as a register
Src1_EXE  in  5  rs in EXE
Src2_EXE  in  5  rt in EXE
is_Immediate_EXE  in  1  EXE operand B is immediate
Dst_EXE  in  5  destination in EXE
WB_EN_EXE  in  1  EXE writes back
MEM_R_EN_EXE  in  1  EXE instruction is a load
Dst_MEM  in  5  destination in MEM
WB_EN_MEM  in  1  MEM writes back
MEM_req  in  1  MEM-stage instruction accesses data memory (load or store)
Dst_WB  in  5  destination in WB
WB_EN_WB  in  1  WB writes back
Br_taken  in  1  branch resolved taken in EXE
Freeze  out  1  hold PC and IF/ID register
Flush_IF  out  1  clear IF/ID register
Flush_ID  out  1  insert bubble into ID/EXE register
Hold_all  out  1  memory wait: every stage register holds
Fwd_A  out  2  operand-A select: 00 reg, 01 MEM result, 10 WB result
Fwd_B  out  2  operand-B select, same encoding
Fwd_ST  out  2  store-data select, same encoding
Stall_cnt  out  CNT_W  saturating count of cycles with Freeze or Hold_all high

Behaviour:
- Reset (rst=0 at posedge): FSM to IDLE, wait counter 0, Stall_cnt 0. Combinational outputs follow inputs with FSM in IDLE.
- Match(x,s) = WB_EN_x & Dst_x!=0 & Dst_x==s; register 0 never matches.
- Hazard, Forward_EN=1: MEM_R_EN_EXE & (Match(EXE,Src1_ID) | Two_src_ID & Match(EXE,Src2_ID)).
- Hazard, Forward_EN=0: any Match(EXE/MEM, Src1_ID or, if Two_src_ID, Src2_ID).
- Forwarding (Forward_EN=1): Fwd_A = 01 if Match(MEM,Src1_EXE), else 10 if Match(WB,Src1_EXE), else 00. Fwd_ST likewise on Src2_EXE. Fwd_B = Fwd_ST unless is_Immediate_EXE, then 00. Forward_EN=0: all 00. MEM priority over WB.
- Memory FSM, states IDLE, WAIT:
  IDLE & MEM_req: Hold_all=1, cnt<=MEM_WAIT-1, go WAIT.
  WAIT & cnt!=0: Hold_all=1, cnt<=cnt-1.
  WAIT & cnt==0: Hold_all=0, go IDLE (pipeline advances this cycle).
  Access spans MEM_WAIT+1 cycles, exactly MEM_WAIT held. Back-to-back accesses: next MEM_req is sampled in IDLE the cycle after release. MEM_req is ignored while in WAIT.
- Priority when Hold_all=1: Freeze=1, Flush_IF=0, Flush_ID=0. Branch/hazard are re-evaluated after release (inputs are held by frozen stages).
- Hold_all=0: Br_taken → Flush_IF=1, Flush_ID=1, Freeze=0 (branch overrides hazard). Else hazard → Freeze=1, Flush_ID=1, Flush_IF=0. Else all 0.
- Stall_cnt increments each cycle Freeze=1, saturates at all-ones.
- Reset mid-WAIT: returns to IDLE next edge, Hold_all drops immediately after.

Test Plan:
- Reset: rst=0 during WAIT with MEM_req=1 → next cycle IDLE, Hold_all=0, Stall_cnt=0.
- Load-use: Forward_EN=1, MEM_R_EN_EXE=1, WB_EN_EXE=1, Dst_EXE=5, Src1_ID=5 → Freeze=1, Flush_ID=1 for one cycle; Dst_EXE=0 → no hazard.
- Forwarding: Dst_MEM=Dst_WB=7, both WB_EN, Src1_EXE=7 → Fwd_A=01; WB_EN_MEM=0 → 10; Src2_EXE=7, is_Immediate_EXE=1 → Fwd_B=00, Fwd_ST=10.
- Memory wait MEM_WAIT=3: single-cycle MEM_req pulse → Hold_all high exactly 3 cycles, then low; MEM_req held high 8 cycles → pattern 1,1,1,0,1,1,1,0.
- Branch vs hazard: Br_taken=1 with load-use hazard → Flush_IF=1, Flush_ID=1, Freeze=0; same during Hold_all → all flushes 0, Freeze=1.
- No-forward mode: Forward_EN=0, Match(MEM,Src2_ID), Two_src_ID=1 → Freeze=1; Two_src_ID=0 → 0; Stall_cnt saturation with CNT_W=4 after 20 stall cycles → 15.
